// File: rtl/mips_muldiv_unit.sv
// MIPS HI/LO multiply/divide unit: iterative radix-2 shift-add multiply and restoring divide.
// Optional MIPS_MULDIV_FAST_MUL_EN makes MULT/MULTU single-cycle combinational; divide stays iterative.
module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             is_div_q, is_div_d;
  logic             neg_main_q, neg_main_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic             op_signed;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_borrow;
  logic [WIDTH-1:0] div_diff;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign sign_a    = op_signed && op_a[WIDTH-1];
  assign sign_b    = op_signed && op_b[WIDTH-1];
  assign abs_a     = sign_a ? -op_a : op_a;
  assign abs_b     = sign_b ? -op_b : op_b;

  // Datapath works on magnitudes; signs are reapplied once in FINISH.
  assign mul_sum    = {1'b0, acc_q} + (sh_q[0] ? {1'b0, mcand_q} : '0);
  assign div_shift  = {acc_q, sh_q[WIDTH-1]};
  assign div_borrow = div_shift < {1'b0, mcand_q};
  assign div_diff   = div_shift[WIDTH-1:0] - mcand_q;

  assign product  = {acc_q, sh_q};
  assign prod_fix = neg_main_q ? -product : product;
  assign quo_fix  = dz_q ? '1 : (neg_main_q ? -sh_q : sh_q);
  assign rem_fix  = neg_rem_q ? -acc_q : acc_q;

`ifdef MIPS_MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [2*WIDTH-1:0] fast_prod;

  assign ext_a     = {{WIDTH{sign_a}}, op_a};
  assign ext_b     = {{WIDTH{sign_b}}, op_b};
  assign fast_prod = ext_a * ext_b;
`endif

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    is_div_d   = is_div_q;
    neg_main_d = neg_main_q;
    neg_rem_d  = neg_rem_q;
    dz_d       = dz_q;
    acc_d      = acc_q;
    sh_d       = sh_q;
    mcand_d    = mcand_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MTHI: begin
              hi_d   = op_a;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = op_a;
              done_d = 1'b1;
            end
            OP_MULT, OP_MULTU: begin
`ifdef MIPS_MULDIV_FAST_MUL_EN
              hi_d   = fast_prod[2*WIDTH-1:WIDTH];
              lo_d   = fast_prod[WIDTH-1:0];
              done_d = 1'b1;
`else
              state_d    = CALC;
              count_d    = '0;
              is_div_d   = 1'b0;
              neg_main_d = sign_a ^ sign_b;
              neg_rem_d  = 1'b0;
              dz_d       = 1'b0;
              acc_d      = '0;
              sh_d       = abs_b;
              mcand_d    = abs_a;
`endif
            end
            OP_DIV, OP_DIVU: begin
              state_d    = CALC;
              count_d    = '0;
              is_div_d   = 1'b1;
              neg_main_d = sign_a ^ sign_b;
              neg_rem_d  = sign_a;
              dz_d       = (op_b == '0);
              acc_d      = '0;
              sh_d       = abs_a;
              mcand_d    = abs_b;
            end
            default: ;
          endcase
        end
      end
      CALC: begin
        if (is_div_q) begin
          acc_d = div_borrow ? div_shift[WIDTH-1:0] : div_diff;
          sh_d  = {sh_q[WIDTH-2:0], ~div_borrow};
        end else begin
          acc_d = mul_sum[WIDTH:1];
          sh_d  = {mul_sum[0], sh_q[WIDTH-1:1]};
        end
        count_d = count_q + CW'(1);
        if (count_q == LAST_STEP) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      is_div_q   <= 1'b0;
      neg_main_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      acc_q      <= '0;
      sh_q       <= '0;
      mcand_q    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      is_div_q   <= is_div_d;
      neg_main_q <= neg_main_d;
      neg_rem_q  <= neg_rem_d;
      dz_q       <= dz_d;
      acc_q      <= acc_d;
      sh_q       <= sh_d;
      mcand_q    <= mcand_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit: 32-bit instance for the main checks, 16-bit instance for width scaling.
module tb_mips_muldiv_unit;

  localparam int W = 32;
`ifdef MIPS_MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W + 2;
`endif
  localparam int DIV_LAT = W + 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [2:0]    op;
  logic [W-1:0]  op_a, op_b, hi, lo;
  logic          busy, done;

  logic          s_start;
  logic [2:0]    s_op;
  logic [15:0]   s_a, s_b, s_hi, s_lo;
  logic          s_busy, s_done;

  always #5 clk = ~clk;

  mips_muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  mips_muldiv_unit #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(s_start), .op(s_op), .op_a(s_a), .op_b(s_b),
    .busy(s_busy), .done(s_done), .hi(s_hi), .lo(s_lo)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;
    int          lat;
    string       name;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] cur_hi, cur_lo;
  int          total = 0;
  int          bad = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Reference model: plain SV arithmetic plus the MIPS corner cases.
  task automatic computeExpected(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] eh, output logic [31:0] el, output int lat);
    logic [63:0] p;
    eh = cur_hi;
    el = cur_lo;
    lat = DIV_LAT;
    case (o)
      3'd0: begin
        p = longint'($signed(a)) * longint'($signed(b));
        eh = p[63:32]; el = p[31:0]; lat = MUL_LAT;
      end
      3'd1: begin
        p = {32'b0, a} * {32'b0, b};
        eh = p[63:32]; el = p[31:0]; lat = MUL_LAT;
      end
      3'd2: begin
        if (b == 32'd0) begin
          el = 32'hFFFF_FFFF; eh = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          el = 32'h8000_0000; eh = 32'd0;
        end else begin
          el = $signed(a) / $signed(b);
          eh = $signed(a) % $signed(b);
        end
      end
      3'd3: begin
        if (b == 32'd0) begin
          el = 32'hFFFF_FFFF; eh = a;
        end else begin
          el = a / b; eh = a % b;
        end
      end
      3'd4: begin eh = a; lat = 1; end
      default: begin el = a; lat = 1; end
    endcase
  endtask

  // Drive one command at a negedge, push its expectation, return at the negedge after acceptance.
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input string name);
    exp_t e;
    computeExpected(o, a, b, e.hi, e.lo, e.lat);
    e.prev_hi = cur_hi;
    e.prev_lo = cur_lo;
    e.name = name;
    cur_hi = e.hi;
    cur_lo = e.lo;
    sbq.push_back(e);
    start = 1'b1; op = o; op_a = a; op_b = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic checkResult();
    exp_t e;
    int   k;
    int   busy_cnt;
    int   hold_bad;
    bit   seen;
    if (sbq.size() == 0) begin
      checkOutput("sb_empty", 64'(sbq.size()), 64'd1);
      return;
    end
    e = sbq.pop_front();
    k = 1; busy_cnt = 0; hold_bad = 0; seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      if (hi !== e.prev_hi || lo !== e.prev_lo) hold_bad++;
      @(negedge clk);
      k++;
    end
    checkOutput({e.name, "_done_seen"}, 64'(seen), 64'd1);
    checkOutput({e.name, "_latency"}, 64'(k), 64'(e.lat));
    checkOutput({e.name, "_busy_cycles"}, 64'(busy_cnt), 64'(e.lat - 1));
    checkOutput({e.name, "_hold"}, 64'(hold_bad), 64'd0);
    checkOutput({e.name, "_hi"}, 64'(hi), 64'(e.hi));
    checkOutput({e.name, "_lo"}, 64'(lo), 64'(e.lo));
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    int          busy_cnt;
    int          done_cnt;

    reset = 1'b1; start = 1'b0; op = 3'd0; op_a = '0; op_b = '0;
    s_start = 1'b0; s_op = 3'd0; s_a = '0; s_b = '0;
    cur_hi = '0; cur_lo = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_hi", 64'(hi), 64'd0);
    checkOutput("rst_lo", 64'(lo), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    applyStimulus(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    checkResult();
    @(negedge clk);
    checkOutput("done_one_cycle", 64'(done), 64'd0);

    applyStimulus(3'd0, 32'hFFFF_FFFE, 32'h0000_0003, "mult_neg");
    checkResult();
    applyStimulus(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, "div_m7_2");
    checkResult();
    applyStimulus(3'd3, 32'h0000_0007, 32'h0000_0000, "divu_by0");
    checkResult();
    applyStimulus(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
    checkResult();
    applyStimulus(3'd2, 32'hFFFF_FFF7, 32'h0000_0000, "div_neg_by0");
    checkResult();
    applyStimulus(3'd0, 32'h8000_0000, 32'h8000_0000, "mult_min_min");
    checkResult();

    applyStimulus(3'd4, 32'h1234_5678, 32'h0, "mthi");
    checkResult();
    applyStimulus(3'd5, 32'h9ABC_DEF0, 32'h0, "mtlo");
    checkResult();
    @(negedge clk);

    start = 1'b1; op = 3'b110; op_a = 32'hDEAD_BEEF; op_b = 32'h1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checkOutput("rsvd_done", 64'(done), 64'd0);
    checkOutput("rsvd_busy", 64'(busy), 64'd0);
    checkOutput("rsvd_hi", 64'(hi), 64'(cur_hi));
    checkOutput("rsvd_lo", 64'(lo), 64'(cur_lo));

    for (int i = 0; i < 10; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(0, 5)) : $urandom;
      if (i % 4 == 1) rb = -rb;
      applyStimulus(ro, ra, rb, $sformatf("rand%0d_op%0d", i, ro));
      checkResult();
      if (i % 2 == 0) @(negedge clk);
    end

    // DIVU in flight, MTLO attempted while busy, then reset mid-operation.
    start = 1'b1; op = 3'd3; op_a = 32'd100; op_b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    op = 3'd5; op_a = 32'h5555_5555;
    repeat (3) @(negedge clk);
    start = 1'b0;
    checkOutput("mid_busy", 64'(busy), 64'd1);
    checkOutput("mtlo_ignored", 64'(lo), 64'(cur_lo));
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_hi", 64'(hi), 64'd0);
    checkOutput("midrst_lo", 64'(lo), 64'd0);
    reset = 1'b0;
    cur_hi = '0; cur_lo = '0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    checkOutput("midrst_no_done", 64'(done_cnt), 64'd0);
    checkOutput("midrst_lo_after", 64'(lo), 64'd0);

    s_start = 1'b1; s_op = 3'd3; s_a = 16'hFFFF; s_b = 16'h0010;
    @(posedge clk);
    @(negedge clk);
    s_start = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!s_busy) break;
      busy_cnt++;
      @(negedge clk);
    end
    checkOutput("w16_busy_cycles", 64'(busy_cnt), 64'd17);
    checkOutput("w16_done", 64'(s_done), 64'd1);
    checkOutput("w16_lo", 64'(s_lo), 64'h0FFF);
    checkOutput("w16_hi", 64'(s_hi), 64'h000F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
